// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: decodes op/funct and sequences one instruction at a time
// through shared instruction/data memory, stalling on mem_rdy.
module mc_ctrl_fsm #(
  parameter bit STALL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic       EXTOp,
  output logic [1:0] NPCOp,
  output logic [1:0] WDSel,
  output logic [1:0] GPRSel,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    StFetch = 4'd0,
    StDcd   = 4'd1,
    StExe   = 4'd2,
    StAwb   = 4'd3,
    StMa    = 4'd4,
    StMr    = 4'd5,
    StMwb   = 4'd6,
    StMw    = 4'd7,
    StBr    = 4'd8,
    StJmp   = 4'd9
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  state_e state_q, state_d;

  logic       rdy;
  logic       is_r, r_ok, is_jr, is_exe, is_mem, is_br, is_jmp;
  logic [3:0] r_alu;

  assign rdy = STALL_EN ? mem_rdy : 1'b1;

  always_comb begin
    is_r  = (op == OpRtype);
    r_ok  = 1'b1;
    r_alu = 4'd0;
    case (funct)
      6'b100000: r_alu = 4'd1;
      6'b100010: r_alu = 4'd2;
      6'b100100: r_alu = 4'd3;
      6'b100101: r_alu = 4'd4;
      6'b101010: r_alu = 4'd5;
      6'b000000: r_alu = 4'd6;
      6'b000010: r_alu = 4'd7;
      default:   r_ok  = 1'b0;
    endcase
    is_jr  = is_r && (funct == 6'b001000);
    is_exe = (is_r && r_ok) || (op == OpAddi) || (op == OpOri) || (op == OpLui);
    is_mem = (op == OpLw) || (op == OpSw);
    is_br  = (op == OpBeq) || (op == OpBne);
    is_jmp = (op == OpJ) || (op == OpJal) || is_jr;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: if (rdy) state_d = StDcd;
      StDcd: begin
        if (is_mem)      state_d = StMa;
        else if (is_exe) state_d = StExe;
        else if (is_br)  state_d = StBr;
        else if (is_jmp) state_d = StJmp;
        else             state_d = StFetch;
      end
      StExe:   state_d = StAwb;
      StMa:    state_d = (op == OpLw) ? StMr : StMw;
      StMr:    if (rdy) state_d = StMwb;
      StMw:    if (rdy) state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 4'd0;
    EXTOp      = 1'b1;
    NPCOp      = 2'b00;
    WDSel      = 2'b00;
    GPRSel     = 2'b00;
    state      = 4'd0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    // Reset forces every output low, including EXTOp and the debug state.
    if (rst) begin
      EXTOp = 1'b0;
    end else begin
      state = state_q;
      case (state_q)
        StFetch: begin
          ALUSrcB = 2'b01;
          ALUOp   = 4'd1;
          PCWrite = rdy;
          IRWrite = rdy;
        end
        StDcd: begin
          ALUSrcB = 2'b11;
          ALUOp   = 4'd1;
          if (!(is_mem || is_exe || is_br || is_jmp)) begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        end
        StExe: begin
          ALUSrcA = 1'b1;
          if (is_r) begin
            ALUOp = r_alu;
          end else begin
            ALUSrcB = 2'b10;
            if (op == OpOri) begin
              ALUOp = 4'd4;
              EXTOp = 1'b0;
            end else if (op == OpLui) begin
              ALUOp = 4'd8;
            end else begin
              ALUOp = 4'd1;
            end
          end
        end
        StAwb: begin
          RegWrite   = 1'b1;
          GPRSel     = is_r ? 2'b00 : 2'b01;
          instr_done = 1'b1;
        end
        StMa: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 4'd1;
        end
        StMr: IorD = 1'b1;
        StMwb: begin
          RegWrite   = 1'b1;
          WDSel      = 2'b01;
          GPRSel     = 2'b01;
          instr_done = 1'b1;
        end
        StMw: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = rdy;
        end
        StBr: begin
          ALUSrcA    = 1'b1;
          ALUOp      = 4'd2;
          NPCOp      = 2'b01;
          PCWrite    = (op == OpBeq) ? zero : ~zero;
          instr_done = 1'b1;
        end
        StJmp: begin
          PCWrite    = 1'b1;
          NPCOp      = is_jr ? 2'b11 : 2'b10;
          instr_done = 1'b1;
          if (op == OpJal) begin
            RegWrite = 1'b1;
            WDSel    = 2'b10;
            GPRSel   = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
